// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the iterative odd-even transposition sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } sort_state_t;

  // Width of the phase counter: must hold the value N without wrapping.
  function automatic int phase_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Compare-exchange cell for one adjacent pair: a/lo is slot k, b/hi is slot k+1.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int W          = 2,
  parameter int MAX_AT_TOP = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  // Strict compare only, so equal keys keep their order.
  assign swapped = (MAX_AT_TOP != 0) ? (a > b) : (a < b);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/sort_engine.sv
// Iterative odd-even transposition sorter with valid/ready on both sides.
// Optional early exit on two clean phases is enabled by defining SORT_EARLY_EXIT_EN.
module sort_engine
  import sort_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = 2,
  parameter int MAX_AT_TOP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   out_data,
`ifdef SORT_EARLY_EXIT_EN
  output logic [$clog2(N):0] last_phases,
`endif
  output logic             busy
);

  localparam int CW = phase_cnt_w(N);
  localparam int NE = N / 2;
  localparam int NO = (N - 1) / 2;

  sort_state_t             state_reg, state_next;
  logic [N-1:0][W-1:0]     elem_reg, elem_next;
  logic [CW-1:0]           phase_reg, phase_next;
  logic [N-1:0][W-1:0]     even_res, odd_res;

`ifdef SORT_EARLY_EXIT_EN
  logic [NE:0]             even_sw;
  logic [NO:0]             odd_sw;
  logic                    any_swap;
  logic                    clean_reg, clean_next;
  logic [CW-1:0]           last_reg, last_next;

  assign even_sw[NE]  = 1'b0;
  assign odd_sw[NO]   = 1'b0;
  assign any_swap     = phase_reg[0] ? (|odd_sw) : (|even_sw);
  assign last_phases  = last_reg;
`endif

  // Even phase: pairs (0,1),(2,3)...
  generate
    for (genvar gi = 0; gi < NE; gi++) begin : g_even
      sort_cmp_swap #(.W(W), .MAX_AT_TOP(MAX_AT_TOP)) u_cell (
        .a       (elem_reg[2*gi]),
        .b       (elem_reg[2*gi+1]),
        .lo      (even_res[2*gi]),
        .hi      (even_res[2*gi+1]),
`ifdef SORT_EARLY_EXIT_EN
        .swapped (even_sw[gi])
`else
        .swapped ()
`endif
      );
    end
    if (N % 2 == 1) begin : g_even_tail
      assign even_res[N-1] = elem_reg[N-1];
    end
  endgenerate

  // Odd phase: pairs (1,2),(3,4)...; slot 0 and an unpaired top slot hold.
  generate
    for (genvar gi = 0; gi < NO; gi++) begin : g_odd
      sort_cmp_swap #(.W(W), .MAX_AT_TOP(MAX_AT_TOP)) u_cell (
        .a       (elem_reg[2*gi+1]),
        .b       (elem_reg[2*gi+2]),
        .lo      (odd_res[2*gi+1]),
        .hi      (odd_res[2*gi+2]),
`ifdef SORT_EARLY_EXIT_EN
        .swapped (odd_sw[gi])
`else
        .swapped ()
`endif
      );
    end
    assign odd_res[0] = elem_reg[0];
    if (N % 2 == 0) begin : g_odd_tail
      assign odd_res[N-1] = elem_reg[N-1];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    elem_next  = elem_reg;
    phase_next = phase_reg;
`ifdef SORT_EARLY_EXIT_EN
    clean_next = clean_reg;
    last_next  = last_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          elem_next  = in_data;
          phase_next = '0;
          state_next = SORT;
`ifdef SORT_EARLY_EXIT_EN
          clean_next = 1'b0;
`endif
        end
      end
      SORT: begin
        elem_next  = phase_reg[0] ? odd_res : even_res;
        phase_next = phase_reg + 1'b1;
        if (phase_reg == CW'(N - 1)) state_next = DONE;
`ifdef SORT_EARLY_EXIT_EN
        clean_next = ~any_swap;
        // N=2 has an empty odd phase, so one clean even phase already proves order.
        if (!any_swap && (clean_reg || (N == 2))) state_next = DONE;
        if (state_next == DONE) last_next = phase_reg + 1'b1;
`endif
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      elem_reg  <= '0;
      phase_reg <= '0;
`ifdef SORT_EARLY_EXIT_EN
      clean_reg <= 1'b0;
      last_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      elem_reg  <= elem_next;
      phase_reg <= phase_next;
`ifdef SORT_EARLY_EXIT_EN
      clean_reg <= clean_next;
      last_reg  <= last_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == SORT);
  assign out_valid = (state_reg == DONE);
  assign out_data  = elem_reg;

endmodule

// File: tb/tb_sort_engine.sv
// Directed self-checking bench for sort_engine (N=4/W=2 ascending and N=5/W=4 descending instances).
module tb_sort_engine;

  typedef struct {
    logic [19:0] data;
    int          lat;
  } exp_t;

`ifdef SORT_EARLY_EXIT_EN
  localparam int L55 = 2;
  localparam int LE4 = 2;
  localparam int L5  = 4;
`else
  localparam int L55 = 4;
  localparam int LE4 = 4;
  localparam int L5  = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_data, out_data;
  logic        in5_valid, in5_ready, out5_valid, out5_ready, busy5;
  logic [19:0] in5_data, out5_data;
`ifdef SORT_EARLY_EXIT_EN
  logic [2:0]  lp4;
  logic [3:0]  lp5;
`endif

  sort_engine #(.N(4), .W(2), .MAX_AT_TOP(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef SORT_EARLY_EXIT_EN
    .last_phases(lp4),
`endif
    .busy       (busy)
  );

  sort_engine #(.N(5), .W(4), .MAX_AT_TOP(0)) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in5_valid),
    .in_ready   (in5_ready),
    .in_data    (in5_data),
    .out_valid  (out5_valid),
    .out_ready  (out5_ready),
    .out_data   (out5_data),
`ifdef SORT_EARLY_EXIT_EN
    .last_phases(lp5),
`endif
    .busy       (busy5)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t q4[$];
  exp_t q5[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic job4(input logic [7:0] d, input logic [7:0] expd, input int lat, input int hold);
    int   cnt;
    int   busy_cnt;
    exp_t e;
    cnt = 0;
    while (!in_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("ready_before_job", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    e.data = 20'(expd);
    e.lat  = lat;
    q4.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    cnt = 0;
    busy_cnt = 0;
    while (!out_valid && cnt < 50) begin
      if (busy) busy_cnt++;
      check("in_ready_while_sort", in_ready, 0);
      @(posedge clk); #1;
      cnt++;
    end
    e = q4.pop_front();
    check("latency", cnt, e.lat);
    check("busy_cycles", busy_cnt, e.lat);
    check("out_data", out_data, e.data);
    check("in_ready_in_done", in_ready, 0);
`ifdef SORT_EARLY_EXIT_EN
    check("last_phases", lp4, e.lat);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'(i * 37);
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, e.data);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    if (hold > 0) begin
      @(posedge clk); #1;
      check("idle_after_bp", in_ready, 1);
    end
    $display("job4 in=%h out=%h latency=%0d", d, out_data, cnt);
  endtask

  task automatic job5(input logic [19:0] d, input logic [19:0] expd, input int lat);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (!in5_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("ready5_before_job", in5_ready, 1);
    in5_valid = 1'b1;
    in5_data  = d;
    e.data = expd;
    e.lat  = lat;
    q5.push_back(e);
    @(posedge clk); #1;
    in5_valid = 1'b0;
    in5_data  = '1;
    cnt = 0;
    while (!out5_valid && cnt < 50) begin @(posedge clk); #1; cnt++; end
    e = q5.pop_front();
    check("latency5", cnt, e.lat);
    check("out5_data", out5_data, e.data);
`ifdef SORT_EARLY_EXIT_EN
    check("last_phases5", lp5, e.lat);
`endif
    out5_ready = 1'b1;
    @(posedge clk); #1;
    out5_ready = 1'b0;
    check("release5_in_ready", in5_ready, 1);
    $display("job5 in=%h out=%h latency=%0d", d, out5_data, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dropped;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    in5_valid  = 1'b0;
    in5_data   = '0;
    out5_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst5_out_data", out5_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    job4(8'h1B, 8'hE4, 4, 0);
    job4(8'h55, 8'h55, L55, 0);
    job4(8'h96, 8'hA5, 4, 0);
    job4(8'hE4, 8'hE4, LE4, 10);

    // Reset two cycles after accept: job is lost, outputs return to reset values.
    while (!in_ready) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = 8'h1B;
    dropped.data = 20'hE4;
    dropped.lat  = 4;
    q4.push_back(dropped);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_data", out_data, 0);
    dropped = q4.pop_back();
    $display("abort job in=1b dropped expected=%h", dropped.data);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    job4(8'h1B, 8'hE4, 4, 0);
    job5(20'h03739, 20'h03379, L5);

    check("queue4_empty", q4.size(), 0);
    check("queue5_empty", q5.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort_engine.md
Name: sort_engine

Overview:
- Parametrised, clocked, iterative sorter for N unsigned W-bit elements.
- Uses odd-even transposition sort: one compare-exchange phase per clock over a registered element array.
- Has a valid/ready handshake on both sides, so it drops into streaming datapaths in place of purely combinational fixed-size sorting networks.

Parameters:
- N, 4, number of elements; legal range N >= 2.
- W, 2, element width in bits, unsigned compare.
- MAX_AT_TOP, 1: 1 places the maximum at element N-1 (descending from top slot); 0 places the minimum at element N-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a vector to sort
- in_ready  output  1  engine can accept a vector (state IDLE)
- in_data  input  N*W  element k = in_data[k*W +: W]
- out_valid  output  1  out_data holds the sorted vector
- out_ready  input  1  consumer accepts out_data
- out_data  output  N*W  sorted vector, same element packing as in_data
- busy  output  1  state is SORT

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE
  - element array = 0
  - phase counter = 0
  - out_valid = 0, busy = 0, in_ready = 1 (decoded from IDLE)
  - out_data = 0
- States: IDLE, SORT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a clock edge, load all N elements, clear the phase counter, and go to SORT.
- SORT:
  - Each cycle performs phase p = counter.
  - Even p compares pairs (0,1),(2,3)…; odd p compares pairs (1,2),(3,4)….
  - An element with no partner (N odd, or the ends) holds its value.
  - Swap only when strictly out of order. Equal values never swap, so the sort is stable.
  - For MAX_AT_TOP=1, swap pair (k,k+1) when e[k] > e[k+1]. For MAX_AT_TOP=0, swap when e[k] < e[k+1].
  - After phase N-1 completes, go to DONE.
- Latency: if the accept edge is cycle 0, out_valid rises after the edge of cycle N. Total SORT cycles = N, which guarantees a sorted result for any input.
- DONE:
  - out_valid = 1 and out_data = element array, both stable while out_ready = 0.
  - On out_ready at an edge, go to IDLE. in_ready is 1 from the next cycle; there is no same-cycle turnaround.
- in_valid is ignored outside IDLE. in_data is sampled only at the accept edge, so later changes have no effect.
- Phase counter width: $clog2(N)+1 bits, no wrap within a job.
- Reset asserted mid-SORT or mid-DONE aborts the job immediately; all registers return to reset values and the result is lost.
- All outputs are registered or decoded directly from state registers, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- Defined:
  - A per-phase swap flag is tracked.
  - If two consecutive phases (one even, one odd) perform no swaps, go to DONE after the second, even if p < N-1.
  - Minimum SORT duration is 2 cycles; maximum is still N.
  - Special case N=2: the odd phase is empty, so the first clean even phase is sufficient.
  - Adds output last_phases [$clog2(N):0] = number of SORT cycles used. It is updated at DONE entry and resets to 0.
- Undefined: SORT always takes exactly N cycles, and last_phases does not exist.

Decomposition:
- Package sort_pkg:
  - state enum sort_state_t {IDLE, SORT, DONE}
  - localparam function for phase counter width
- Sub-module sort_cmp_swap (parameters W, MAX_AT_TOP):
  - Combinational compare-exchange of two W-bit values.
  - Outputs hi/lo and a swapped flag.
- sort_engine instantiates floor(N/2) cells for even phases and floor((N-1)/2) cells for odd phases, and muxes the results by phase parity.

Test Plan:
- N=4, W=2, MAX_AT_TOP=1; in_data=8'h1B (e3..e0=0,1,2,3) -> out_data=8'hE4 (3,2,1,0). out_valid is first high exactly 4 cycles after the accept edge. busy is high for 4 cycles.
- Duplicates: in_data=8'h55 -> out_data=8'h55, with no swaps. In_data=8'h96 (2,1,1,2) -> 8'hA5 (2,2,1,1).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stay stable, in_ready stays 0, and in_valid pulses are ignored. After out_ready=1, in_ready=1 the next cycle.
- Reset mid-sort: assert rst_n=0 two cycles after accept -> out_valid=0, in_ready=1, out_data=0 immediately. A new job 8'h1B then completes normally with 8'hE4.
- MAX_AT_TOP=0, N=5, W=4; elements 9,3,7,3,0 -> elements e4..e0 = 0,3,3,7,9. Latency is 5 cycles.
- With SORT_EARLY_EXIT_EN, N=4; in_data=8'hE4 (already sorted) -> out_valid after 2 cycles and last_phases=2. Without the macro, latency is 4 cycles.
